// File: rtl/rc4_sched_pkg.sv
// Shared types and defaults for the RC4 key-search scheduler.
// The key width and search-space end are overridable per instance.
package rc4_sched_pkg;

    localparam int KEY_W = 24;
    localparam logic [KEY_W-1:0] KEY_MAX_DEFAULT = 24'h3FFFFF;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        FOUND,
        FAIL
    } sched_state_t;

endpackage

// File: rtl/rr_idle_picker.sv
// Round-robin first-idle selector: lowest offset from ptr_i wins.
// Purely combinational; the caller registers the grant.
module rr_idle_picker #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  idle_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] grant_o,
    output logic          valid_o
);

    int idx;

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = 0;
        // Scan from the far end so the nearest idle core overwrites.
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr_i) + k) % N;
            if (idle_i[idx]) begin
                grant_o = PW'(idx);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rc4_key_scheduler.sv
// Central key sequencer for N parallel RC4 cracking cores:
// dispatches keys, tracks busy cores and captures the winning key.
module rc4_key_scheduler #(
    parameter int N_CORES = 4,
    parameter int KEY_W = rc4_sched_pkg::KEY_W,
    parameter logic [KEY_W-1:0] KEY_MAX =
        KEY_W'(rc4_sched_pkg::KEY_MAX_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic [N_CORES-1:0]       core_launch,
    output logic [N_CORES*KEY_W-1:0] core_key,
    input  logic [N_CORES-1:0]       core_done,
    input  logic [N_CORES-1:0]       core_hit,
    output logic                     core_stop,
    output logic                     busy,
    output logic                     found,
    output logic                     exhausted,
    output logic [KEY_W-1:0]         found_key,
    output logic [KEY_W:0]           keys_done
);

    import rc4_sched_pkg::*;

    localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam logic [KEY_W:0] DONE_CAP =
        {1'b0, KEY_MAX} + {{KEY_W{1'b0}}, 1'b1};

    sched_state_t state_q, state_d;

    logic                flush_q;
    logic [N_CORES-1:0]  launch_q;
    logic [KEY_W-1:0]    core_key_q [N_CORES];
    logic [N_CORES-1:0]  busy_q;
    logic [KEY_W-1:0]    next_key_q;
    logic [PW-1:0]       rr_ptr_q;
    logic [KEY_W-1:0]    found_key_q;
    logic [KEY_W:0]      keys_done_q;

    logic                active;
    logic [N_CORES-1:0]  acc;
    logic [N_CORES-1:0]  hit_v;
    logic [N_CORES-1:0]  busy_nx;
    logic                hit_any;
    logic [KEY_W-1:0]    hit_key;
    logic [PW-1:0]       grant;
    logic                grant_vld;
    logic                dispatch;
    logic [N_CORES-1:0]  grant_oh;
    logic [PW-1:0]       rr_next;
    logic [KEY_W:0]      done_cnt;
    logic [KEY_W+1:0]    keys_sum;
    logic [KEY_W:0]      keys_done_d;

    rr_idle_picker #(
        .N  (N_CORES),
        .PW (PW)
    ) u_picker (
        .idle_i  (~busy_q),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .valid_o (grant_vld)
    );

    // Results count only from busy cores while a search is live.
    always_comb begin
        active  = (state_q == RUN) || (state_q == DRAIN);
        acc     = core_done & busy_q & {N_CORES{active}};
        hit_v   = acc & core_hit;
        busy_nx = busy_q & ~acc;
        hit_any = 1'b0;
        hit_key = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (hit_v[i]) begin
                hit_any = 1'b1;
                hit_key = core_key_q[i];
            end
        end
    end

    always_comb begin
        dispatch = (state_q == RUN) && !start && !hit_any && grant_vld;
        grant_oh = dispatch ? (N_CORES'(1) << grant) : '0;
        rr_next  = (int'(grant) == N_CORES - 1) ? '0 : grant + 1'b1;
    end

    always_comb begin
        done_cnt = '0;
        for (int i = 0; i < N_CORES; i++) begin
            done_cnt = done_cnt + (KEY_W+1)'(acc[i]);
        end
        keys_sum    = {1'b0, keys_done_q} + {1'b0, done_cnt};
        keys_done_d = (keys_sum > {1'b0, DONE_CAP}) ?
                      DONE_CAP : keys_sum[KEY_W:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (hit_any) begin
                        state_d = FOUND;
                    end else if (dispatch && next_key_q == KEY_MAX) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (hit_any) begin
                        state_d = FOUND;
                    end else if (busy_nx == '0) begin
                        state_d = FAIL;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q == RUN) || (state_q == DRAIN);
        found     = (state_q == FOUND);
        exhausted = (state_q == FAIL);
        core_stop = found || exhausted || flush_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_q     <= 1'b0;
            launch_q    <= '0;
            busy_q      <= '0;
            next_key_q  <= '0;
            rr_ptr_q    <= '0;
            found_key_q <= '0;
            keys_done_q <= '0;
            for (int i = 0; i < N_CORES; i++) begin
                core_key_q[i] <= '0;
            end
        end else begin
            flush_q  <= start;
            launch_q <= grant_oh;
            if (start) begin
                busy_q      <= '0;
                next_key_q  <= '0;
                rr_ptr_q    <= '0;
                found_key_q <= '0;
                keys_done_q <= '0;
            end else begin
                busy_q      <= busy_nx | grant_oh;
                keys_done_q <= keys_done_d;
                if (dispatch) begin
                    core_key_q[grant] <= next_key_q;
                    rr_ptr_q          <= rr_next;
                    if (next_key_q != KEY_MAX) begin
                        next_key_q <= next_key_q + 1'b1;
                    end
                end
                if (hit_any) begin
                    found_key_q <= hit_key;
                end
            end
        end
    end

    always_comb begin
        core_key = '0;
        for (int i = 0; i < N_CORES; i++) begin
            core_key[i*KEY_W +: KEY_W] = core_key_q[i];
        end
        core_launch = launch_q;
        found_key   = found_key_q;
        keys_done   = keys_done_q;
    end

endmodule

// File: tb/tb_rc4_key_scheduler.sv
// Scenario bench for rc4_key_scheduler with a behavioural core model:
// two cores, eight keys, randomised core latency and hit selection.
module tb_rc4_key_scheduler;

    localparam int N = 2;
    localparam int KW = 24;

    logic            clk;
    logic            reset;
    logic            start;
    logic [N-1:0]    core_launch;
    logic [N*KW-1:0] core_key;
    logic [N-1:0]    core_done;
    logic [N-1:0]    core_hit;
    logic            core_stop;
    logic            busy;
    logic            found;
    logic            exhausted;
    logic [KW-1:0]   found_key;
    logic [KW:0]     keys_done;

    rc4_key_scheduler #(
        .N_CORES (N),
        .KEY_W   (KW),
        .KEY_MAX (24'd7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .core_launch (core_launch),
        .core_key    (core_key),
        .core_done   (core_done),
        .core_hit    (core_hit),
        .core_stop   (core_stop),
        .busy        (busy),
        .found       (found),
        .exhausted   (exhausted),
        .found_key   (found_key),
        .keys_done   (keys_done)
    );

    int checks = 0;
    int errors = 0;

    int            cnt [N];
    logic [KW-1:0] ckey [N];
    logic [KW-1:0] launched_key [$];
    int            launched_core [$];
    logic [7:0]    hit_keys;
    int            lat_fixed;
    bit            sync_mode;
    int            dones_driven;
    bit            hit_seen;
    bit            hit_drv;
    bit            hit_edge_passed;
    int            late_launches;
    int            bad_launch;
    logic [KW-1:0] exp_found_key;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            cnt[i]  = 0;
            ckey[i] = '0;
        end
        launched_key.delete();
        launched_core.delete();
        dones_driven    = 0;
        hit_seen        = 0;
        hit_drv         = 0;
        hit_edge_passed = 0;
        late_launches   = 0;
        bad_launch      = 0;
        exp_found_key   = '0;
    endtask

    // One clock: observe the DUT after the edge, then drive core results.
    task automatic step();
        logic [N-1:0] d;
        logic [N-1:0] h;
        @(posedge clk);
        #1;
        if (hit_drv) hit_edge_passed = 1;
        hit_drv = 0;
        d = '0;
        h = '0;
        if (core_stop) begin
            for (int i = 0; i < N; i++) cnt[i] = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) begin
                    d[i] = 1'b1;
                    h[i] = hit_keys[ckey[i][2:0]];
                    dones_driven++;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (core_launch[i]) begin
                if (hit_edge_passed) late_launches++;
                if (cnt[i] != 0) bad_launch++;
                ckey[i] = core_key[i*KW +: KW];
                launched_key.push_back(ckey[i]);
                launched_core.push_back(i);
                if (lat_fixed > 0)
                    cnt[i] = lat_fixed +
                             ((sync_mode && ckey[i] == 24'd4) ? 1 : 0);
                else
                    cnt[i] = int'($urandom_range(4, 1));
            end
        end
        if (h != '0 && !hit_seen) begin
            hit_seen = 1;
            hit_drv  = 1;
            for (int i = N - 1; i >= 0; i--) begin
                if (h[i]) exp_found_key = ckey[i];
            end
        end
        core_done = d;
        core_hit  = h;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        clear_model();
    endtask

    task automatic run_to_end(input string name);
        for (int n = 0; n < 300 && !exhausted && !found; n++) step();
        checks++;
        if (!(exhausted || found)) begin
            errors++;
            $display("FAIL %s_timeout: search did not terminate", name);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({core_launch, core_key, core_stop, busy, found, exhausted,
             found_key, keys_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: launch=%b key=%h stop=%b busy=%b found=%b exh=%b fk=%h kd=%0d",
                     core_launch, core_key, core_stop, busy, found,
                     exhausted, found_key, keys_done);
        end
        reset = 1'b0;
        step();
        step();
        checks++;
        if (core_launch !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: launch=%b busy=%b want 0 0",
                     core_launch, busy);
        end
    endtask

    task automatic check_order(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < launched_key.size(); i++) begin
            if (launched_key[i] != KW'(i)) bad++;
            if (launched_core[i] != i % N) bad++;
        end
        checks++;
        if (launched_key.size() != 8 || bad != 0 || bad_launch != 0) begin
            errors++;
            $display("FAIL %s_order: launches=%0d bad=%0d busy_relaunch=%0d want 8 0 0",
                     name, launched_key.size(), bad, bad_launch);
        end
    endtask

    task automatic test_exhaust();
        lat_fixed = 3;
        sync_mode = 0;
        hit_keys  = 8'h00;
        do_start();
        checks++;
        if (core_stop !== 1'b1 || busy !== 1'b1 ||
            core_launch !== 2'b00 || keys_done !== 25'd0) begin
            errors++;
            $display("FAIL start_flush: stop=%b busy=%b launch=%b kd=%0d want 1 1 00 0",
                     core_stop, busy, core_launch, keys_done);
        end
        step();
        checks++;
        if (core_launch !== 2'b01 || core_key[KW-1:0] !== 24'd0 ||
            core_stop !== 1'b0) begin
            errors++;
            $display("FAIL first_launch: launch=%b key0=%0d stop=%b want 01 0 0",
                     core_launch, core_key[KW-1:0], core_stop);
        end
        run_to_end("exhaust");
        checks++;
        if (exhausted !== 1'b1 || found !== 1'b0 || keys_done !== 25'd8 ||
            core_stop !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL exhaust_final: exh=%b found=%b kd=%0d stop=%b busy=%b want 1 0 8 1 0",
                     exhausted, found, keys_done, core_stop, busy);
        end
        check_order("exhaust");
    endtask

    task automatic test_hit();
        int target;
        lat_fixed = 0;
        sync_mode = 0;
        target    = int'($urandom_range(7, 0));
        hit_keys  = 8'(1 << target);
        do_start();
        run_to_end("hit");
        for (int n = 0; n < 5; n++) step();
        checks++;
        if (found !== 1'b1 || exhausted !== 1'b0 || core_stop !== 1'b1) begin
            errors++;
            $display("FAIL hit_state: found=%b exh=%b stop=%b want 1 0 1",
                     found, exhausted, core_stop);
        end
        checks++;
        if (found_key !== exp_found_key || found_key !== KW'(target)) begin
            errors++;
            $display("FAIL hit_key: got %0d want %0d", found_key, target);
        end
        checks++;
        if (late_launches != 0) begin
            errors++;
            $display("FAIL hit_no_late_launch: %0d launches after hit edge want 0",
                     late_launches);
        end
        checks++;
        if (keys_done !== 25'(dones_driven)) begin
            errors++;
            $display("FAIL hit_keys_done: got %0d want %0d",
                     keys_done, dones_driven);
        end
    endtask

    task automatic test_simul_hit();
        lat_fixed = 3;
        sync_mode = 1;
        hit_keys  = 8'b0011_0000;
        do_start();
        run_to_end("simul");
        checks++;
        if (found !== 1'b1 || found_key !== exp_found_key ||
            found_key !== 24'd4) begin
            errors++;
            $display("FAIL simul_hit_key: found=%b key=%0d want 1 4",
                     found, found_key);
        end
        sync_mode = 0;
    endtask

    task automatic test_spurious();
        lat_fixed = 3;
        hit_keys  = 8'h00;
        do_start();
        step();
        core_done[1] = 1'b1;
        core_hit[1]  = 1'b1;
        step();
        checks++;
        if (keys_done !== 25'd0 || found !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL spurious_done: kd=%0d found=%b busy=%b want 0 0 1",
                     keys_done, found, busy);
        end
        run_to_end("spurious");
        checks++;
        if (exhausted !== 1'b1 || keys_done !== 25'd8) begin
            errors++;
            $display("FAIL spurious_final: exh=%b kd=%0d want 1 8",
                     exhausted, keys_done);
        end
    endtask

    task automatic test_restart();
        lat_fixed = 3;
        hit_keys  = 8'h00;
        do_start();
        for (int n = 0; n < 50 && launched_key.size() < 3; n++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        clear_model();
        checks++;
        if (core_stop !== 1'b1 || core_launch !== 2'b00 ||
            keys_done !== 25'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_flush: stop=%b launch=%b kd=%0d busy=%b want 1 00 0 1",
                     core_stop, core_launch, keys_done, busy);
        end
        step();
        checks++;
        if (core_launch !== 2'b01 || core_key[KW-1:0] !== 24'd0 ||
            core_stop !== 1'b0 || keys_done !== 25'd0) begin
            errors++;
            $display("FAIL restart_launch: launch=%b key0=%0d stop=%b kd=%0d want 01 0 0 0",
                     core_launch, core_key[KW-1:0], core_stop, keys_done);
        end
        run_to_end("restart");
        checks++;
        if (exhausted !== 1'b1 || keys_done !== 25'd8) begin
            errors++;
            $display("FAIL restart_final: exh=%b kd=%0d want 1 8",
                     exhausted, keys_done);
        end
        check_order("restart");
    endtask

    task automatic test_reset_drain();
        int lnum;
        lat_fixed = 3;
        hit_keys  = 8'h00;
        do_start();
        for (int n = 0; n < 60 && launched_key.size() < 8; n++) step();
        checks++;
        if (busy !== 1'b1 || exhausted !== 1'b0) begin
            errors++;
            $display("FAIL drain_state: busy=%b exh=%b want 1 0",
                     busy, exhausted);
        end
        #2;
        reset = 1'b1;
        clear_model();
        core_done = '0;
        core_hit  = '0;
        #1;
        checks++;
        if ({core_launch, core_key, core_stop, busy, found, exhausted,
             found_key, keys_done} !== '0) begin
            errors++;
            $display("FAIL reset_async: launch=%b key=%h stop=%b busy=%b kd=%0d want all 0",
                     core_launch, core_key, core_stop, busy, keys_done);
        end
        step();
        step();
        reset = 1'b0;
        lnum = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (core_launch != '0) lnum++;
        end
        checks++;
        if (lnum != 0 || busy !== 1'b0 || core_stop !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: launches=%0d busy=%b stop=%b want 0 0 0",
                     lnum, busy, core_stop);
        end
    endtask

    initial begin
        start     = 1'b0;
        reset     = 1'b1;
        core_done = '0;
        core_hit  = '0;
        lat_fixed = 3;
        sync_mode = 0;
        hit_keys  = 8'h00;
        clear_model();
        test_reset();
        test_exhaust();
        test_hit();
        test_hit();
        test_simul_hit();
        test_spurious();
        test_restart();
        test_reset_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rc4_key_scheduler.md
# rc4_key_scheduler

Distributes the RC4 secret-key search space across `N_CORES` parallel cracking cores. It issues each idle core a fresh 24-bit key, tracks which cores are busy and collects per-core results. When any core reports a match it stops all cores, or it reports exhaustion once every key has been tried and has failed. It sits above the per-core `s_memory`/initialize/shuffle/decrypt pipelines and replaces per-core key stepping with one central sequencer.

## Interface
- `N_CORES`, default 4: number of cracking cores served (1..8).
- `KEY_W`, default 24: secret-key width.
- `KEY_MAX`, default 24'h3FFFFF: last key in the search space. Keys run 0..`KEY_MAX` inclusive.
- `clk`  in  1  sole clock.
- `reset`  in  1  one clock; reset is asynchronous and active-high.
- `start`  in  1  single-cycle pulse that begins or restarts a search. Accepted in any state.
- `core_launch`  out  `N_CORES`  one-cycle pulse per core: begin processing `core_key[i]`.
- `core_key`  out  `N_CORES*KEY_W`  flattened; slice i is the key for core i.
- `core_done`  in  `N_CORES`  one-cycle pulse from core i: its key has finished.
- `core_hit`  in  `N_CORES`  qualified by `core_done[i]`: key i decrypted to a valid message.
- `core_stop`  out  1  level signal, wired to every core's `stop`. Abort and hold.
- `busy`  out  1  high in RUN and DRAIN.
- `found`  out  1  high in FOUND.
- `exhausted`  out  1  high in FAIL.
- `found_key`  out  `KEY_W`  winning key, valid while `found`.
- `keys_done`  out  `KEY_W+1`  count of `core_done` pulses accepted in the current search.

## Operation
- States: IDLE, RUN, DRAIN, FOUND, FAIL.
- `start` from any state:
  - clears `next_key`, `keys_done`, all core busy bits, `found_key` and the round-robin pointer;
  - moves to RUN.
  - In-flight core results are discarded: busy bits are cleared, and `core_stop` pulses high for that one cycle to flush the cores.
- RUN, dispatch: each cycle at most one launch.
  - The round-robin picker (`rr_idle_picker`) selects the first idle core at or after `rr_ptr`, wrapping modulo `N_CORES`.
  - On a grant: `core_launch[g]` pulses, `core_key[g]` ← `next_key`, `busy[g]` set, `next_key`++, `rr_ptr` ← (g+1) mod `N_CORES`.
  - `core_key[g]` holds stable until the next launch of core g.
- A core whose `core_done` arrives in cycle t is idle from cycle t+1. It is never relaunched in the same cycle as its done.
- `core_done[i]` with `busy[i]`=0 is ignored: no count, no hit.
- Dispatching `KEY_MAX` moves RUN→DRAIN. `next_key` never wraps past `KEY_MAX`.
- Hit (RUN or DRAIN): any accepted `core_done[i]&core_hit[i]` latches `found_key` ← `core_key[i]` and moves to FOUND.
  - With simultaneous hits, the lowest index wins.
- DRAIN→FAIL when all busy bits are 0 and no hit arrived in that cycle.
- FOUND/FAIL are terminal until `start`. `core_stop`=1 in FOUND and FAIL, 0 in IDLE/RUN/DRAIN except the restart flush cycle.
- `core_done` pulses arriving in FOUND/FAIL are ignored.
- `keys_done` saturates at `KEY_MAX`+1.

## Timing
- Reset values:
  - state=IDLE;
  - `core_launch`=0, `core_key`=0, `core_stop`=0;
  - `busy`=0, `found`=0, `exhausted`=0;
  - `found_key`=0, `keys_done`=0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `start` sampled at edge E → state RUN after E → `core_launch[0]` high in the cycle after edge E+1, carrying key 0.
- Hit sampled at edge H → `found`, `core_stop` and `found_key` valid after edge H. No further `core_launch` after edge H−1.
- Sustained dispatch rate is 1 key/cycle when cores are idle. Full occupancy is reached `N_CORES` cycles after the first launch.
- `reset` asserted mid-search clears everything asynchronously. No launch is issued while `reset` is high.

## Structure
- Package `rc4_sched_pkg`:
  - `sched_state_t` enum (IDLE, RUN, DRAIN, FOUND, FAIL);
  - `KEY_W` localparam default;
  - `KEY_MAX_DEFAULT`.
- Sub-module `rr_idle_picker`: combinational round-robin first-idle selector. Inputs are idle mask and pointer; outputs are grant index and valid.
- The top level holds the FSM, key counter, busy mask, per-core key registers and result capture.

## Test plan
- `N_CORES`=2, `KEY_MAX`=7, cores never hit, done 3 cycles after launch → keys 0..7 each launched exactly once, alternating cores; `exhausted`=1, `keys_done`=8, `core_stop`=1.
- Same setup, core 1 hits on key 5 → `found`=1, `found_key`=5; no launch after the hit edge; `exhausted` stays 0.
- `core_done`+`core_hit` on cores 0 and 1 in the same cycle (keys 4 and 5) → `found_key`=4.
- Spurious `core_done[1]` while core 1 idle → `keys_done` unchanged; no state change.
- `start` re-pulsed mid-RUN at `next_key`=3 → one-cycle `core_stop` pulse, then the next launch carries key 0 and `keys_done`=0.
- `reset` asserted in DRAIN → all outputs return to reset values immediately; after release, no launch until `start`.
